// File: rtl/el2_dccm_pkg.sv
// Shared DCCM definitions: address field-width helpers and the per-bank request bundle.
// Fields are sized to the largest supported configuration; users slice them down.
package el2_dccm_pkg;

    localparam int unsigned DCCM_IDX_MAX_W  = 16;
    localparam int unsigned DCCM_DATA_MAX_W = 64;

    function automatic int unsigned bank_bits(input int unsigned num_banks);
        return $clog2(num_banks);
    endfunction

    function automatic int unsigned index_bits(input int unsigned depth);
        return $clog2(depth);
    endfunction

    typedef struct packed {
        logic                       en;
        logic                       we;
        logic [DCCM_IDX_MAX_W-1:0]  index;
        logic [DCCM_DATA_MAX_W-1:0] wdata;
    } el2_dccm_bank_req_t;

endpackage

// File: rtl/el2_dccm_bank_ram.sv
// Behavioural single-port synchronous RAM for one DCCM bank (DEPTH x WIDTH).
// Q holds the last read word; contents are never reset.
module el2_dccm_bank_ram #(
    parameter  int unsigned DEPTH = 1024,
    parameter  int unsigned WIDTH = 39,
    localparam int unsigned ADR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             ME,
    input  logic             WE,
    input  logic [ADR_W-1:0] ADR,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (ME) begin
            if (WE) begin
                mem[ADR] <= D;
            end else begin
                Q <= mem[ADR];
            end
        end
    end

endmodule

// File: rtl/el2_lsu_dccm_arb_mem.sv
// Banked DCCM with LSU (misalignment-capable) / DMA arbitration and DMA starvation guard.
// Define EL2_DCCM_RD_PIPE_EN to add an output register stage (read latency 2).
module el2_lsu_dccm_arb_mem
    import el2_dccm_pkg::*;
#(
    parameter int unsigned NUM_BANKS   = 4,
    parameter int unsigned DATA_W      = 39,
    parameter int unsigned INDEX_DEPTH = 1024,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned STARVE_MAX  = 4
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              clk_override,

    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic              lsu_write,
    input  logic [ADDR_W-1:0] lsu_addr_lo,
    input  logic [ADDR_W-1:0] lsu_addr_hi,
    input  logic [DATA_W-1:0] lsu_wdata_lo,
    input  logic [DATA_W-1:0] lsu_wdata_hi,
    output logic              lsu_rsp_valid,
    output logic [DATA_W-1:0] lsu_rdata_lo,
    output logic [DATA_W-1:0] lsu_rdata_hi,

    input  logic              dma_valid,
    output logic              dma_ready,
    input  logic              dma_write,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_rsp_valid,
    output logic [DATA_W-1:0] dma_rdata
);

    localparam int unsigned BANK_W = bank_bits(NUM_BANKS);
    localparam int unsigned IDX_W  = index_bits(INDEX_DEPTH);
    localparam int unsigned USED_W = 2 + BANK_W + IDX_W;
    localparam int unsigned CNT_W  = $clog2(STARVE_MAX + 1);

    logic [BANK_W-1:0] lo_bank, hi_bank, dma_bank;
    logic [IDX_W-1:0]  lo_idx, hi_idx, dma_idx;
    logic              misaligned;
    logic              starve, lsu_fire, dma_fire;
    logic [CNT_W-1:0]  wait_cnt;

    assign lo_bank  = lsu_addr_lo[2 +: BANK_W];
    assign hi_bank  = lsu_addr_hi[2 +: BANK_W];
    assign dma_bank = dma_addr[2 +: BANK_W];
    assign lo_idx   = lsu_addr_lo[2 + BANK_W +: IDX_W];
    assign hi_idx   = lsu_addr_hi[2 + BANK_W +: IDX_W];
    assign dma_idx  = dma_addr[2 + BANK_W +: IDX_W];

    assign misaligned = (lo_bank != hi_bank);

    assign starve    = (wait_cnt == CNT_W'(STARVE_MAX));
    assign lsu_ready = ~starve;
    assign dma_ready = starve | ~(lsu_valid & ((dma_bank == lo_bank) | (dma_bank == hi_bank)));
    assign lsu_fire  = lsu_valid & lsu_ready;
    assign dma_fire  = dma_valid & dma_ready;

    // Holding at STARVE_MAX is implicit: starve forces dma_ready, so the next cycle fires or drops.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wait_cnt <= '0;
        end else if (!dma_valid || dma_fire) begin
            wait_cnt <= '0;
        end else if (!starve) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    el2_dccm_bank_req_t bank_req [NUM_BANKS];
    logic [DATA_W-1:0]  bank_q   [NUM_BANKS];

    // Arbitration guarantees a DMA fire never shares a bank with an LSU fire.
    always_comb begin
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            bank_req[b]    = '0;
            bank_req[b].en = clk_override;
            if (lsu_fire && (lo_bank == BANK_W'(b))) begin
                bank_req[b].en    = 1'b1;
                bank_req[b].we    = lsu_write;
                bank_req[b].index = DCCM_IDX_MAX_W'(lo_idx);
                bank_req[b].wdata = DCCM_DATA_MAX_W'(lsu_wdata_lo);
            end else if (lsu_fire && misaligned && (hi_bank == BANK_W'(b))) begin
                bank_req[b].en    = 1'b1;
                bank_req[b].we    = lsu_write;
                bank_req[b].index = DCCM_IDX_MAX_W'(hi_idx);
                bank_req[b].wdata = DCCM_DATA_MAX_W'(lsu_wdata_hi);
            end else if (dma_fire && (dma_bank == BANK_W'(b))) begin
                bank_req[b].en    = 1'b1;
                bank_req[b].we    = dma_write;
                bank_req[b].index = DCCM_IDX_MAX_W'(dma_idx);
                bank_req[b].wdata = DCCM_DATA_MAX_W'(dma_wdata);
            end
        end
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        logic unused_req_bits;
        assign unused_req_bits = ^bank_req[g];

        el2_dccm_bank_ram #(
            .DEPTH (INDEX_DEPTH),
            .WIDTH (DATA_W)
        ) u_ram (
            .clk (clk),
            .ME  (bank_req[g].en),
            .WE  (bank_req[g].we),
            .ADR (bank_req[g].index[IDX_W-1:0]),
            .D   (bank_req[g].wdata[DATA_W-1:0]),
            .Q   (bank_q[g])
        );
    end

    logic              lsu_rd_q, dma_rd_q;
    logic [BANK_W-1:0] rsp_lo_bank, rsp_hi_bank, rsp_dma_bank;

    // Aligned accesses steer hi from the lo bank so rdata_hi mirrors rdata_lo.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            lsu_rd_q     <= 1'b0;
            dma_rd_q     <= 1'b0;
            rsp_lo_bank  <= '0;
            rsp_hi_bank  <= '0;
            rsp_dma_bank <= '0;
        end else begin
            lsu_rd_q <= lsu_fire & ~lsu_write;
            dma_rd_q <= dma_fire & ~dma_write;
            if (lsu_fire) begin
                rsp_lo_bank <= lo_bank;
                rsp_hi_bank <= misaligned ? hi_bank : lo_bank;
            end
            if (dma_fire) begin
                rsp_dma_bank <= dma_bank;
            end
        end
    end

    logic [DATA_W-1:0] rd_lo, rd_hi, rd_dma;
    assign rd_lo  = bank_q[rsp_lo_bank];
    assign rd_hi  = bank_q[rsp_hi_bank];
    assign rd_dma = bank_q[rsp_dma_bank];

`ifdef EL2_DCCM_RD_PIPE_EN
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            lsu_rsp_valid <= 1'b0;
            dma_rsp_valid <= 1'b0;
            lsu_rdata_lo  <= '0;
            lsu_rdata_hi  <= '0;
            dma_rdata     <= '0;
        end else begin
            lsu_rsp_valid <= lsu_rd_q;
            dma_rsp_valid <= dma_rd_q;
            lsu_rdata_lo  <= rd_lo;
            lsu_rdata_hi  <= rd_hi;
            dma_rdata     <= rd_dma;
        end
    end
`else
    assign lsu_rsp_valid = lsu_rd_q;
    assign dma_rsp_valid = dma_rd_q;
    assign lsu_rdata_lo  = rd_lo;
    assign lsu_rdata_hi  = rd_hi;
    assign dma_rdata     = rd_dma;
`endif

    logic unused_addr_bits;
    if (ADDR_W > USED_W) begin : g_unused_hi
        assign unused_addr_bits = ^{lsu_addr_lo[1:0], lsu_addr_hi[1:0], dma_addr[1:0],
                                    lsu_addr_lo[ADDR_W-1:USED_W], lsu_addr_hi[ADDR_W-1:USED_W],
                                    dma_addr[ADDR_W-1:USED_W]};
    end else begin : g_unused_lo
        assign unused_addr_bits = ^{lsu_addr_lo[1:0], lsu_addr_hi[1:0], dma_addr[1:0]};
    end

endmodule

// File: tb/tb_el2_lsu_dccm_arb_mem.sv
// Scoreboard bench for el2_lsu_dccm_arb_mem; expected read data comes from a word-level memory model.
module tb_el2_lsu_dccm_arb_mem;

    localparam int AW = 16;
    localparam int DW = 39;
`ifdef EL2_DCCM_RD_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_l = 1'b0;
    logic          clk_override = 1'b0;
    logic          lsu_valid = 1'b0, lsu_write = 1'b0;
    logic [AW-1:0] lsu_addr_lo = '0, lsu_addr_hi = '0;
    logic [DW-1:0] lsu_wdata_lo = '0, lsu_wdata_hi = '0;
    logic          lsu_ready, lsu_rsp_valid;
    logic [DW-1:0] lsu_rdata_lo, lsu_rdata_hi;
    logic          dma_valid = 1'b0, dma_write = 1'b0;
    logic [AW-1:0] dma_addr = '0;
    logic [DW-1:0] dma_wdata = '0;
    logic          dma_ready, dma_rsp_valid;
    logic [DW-1:0] dma_rdata;

    el2_lsu_dccm_arb_mem #(
        .NUM_BANKS   (4),
        .DATA_W      (DW),
        .INDEX_DEPTH (1024),
        .ADDR_W      (AW),
        .STARVE_MAX  (4)
    ) dut (
        .clk           (clk),
        .rst_l         (rst_l),
        .clk_override  (clk_override),
        .lsu_valid     (lsu_valid),
        .lsu_ready     (lsu_ready),
        .lsu_write     (lsu_write),
        .lsu_addr_lo   (lsu_addr_lo),
        .lsu_addr_hi   (lsu_addr_hi),
        .lsu_wdata_lo  (lsu_wdata_lo),
        .lsu_wdata_hi  (lsu_wdata_hi),
        .lsu_rsp_valid (lsu_rsp_valid),
        .lsu_rdata_lo  (lsu_rdata_lo),
        .lsu_rdata_hi  (lsu_rdata_hi),
        .dma_valid     (dma_valid),
        .dma_ready     (dma_ready),
        .dma_write     (dma_write),
        .dma_addr      (dma_addr),
        .dma_wdata     (dma_wdata),
        .dma_rsp_valid (dma_rsp_valid),
        .dma_rdata     (dma_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { int due; logic [DW-1:0] lo; logic [DW-1:0] hi; } lsu_exp_t;
    typedef struct { int due; logic [DW-1:0] d; } dma_exp_t;

    lsu_exp_t      lq[$];
    dma_exp_t      dq[$];
    logic [DW-1:0] mem_model [int];
    int            cyc = 0;
    int            checks = 0;
    int            failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int key(input logic [AW-1:0] a);
        return int'(a[13:2]);
    endfunction

    function automatic logic [1:0] bank(input logic [AW-1:0] a);
        return a[3:2];
    endfunction

    // Response monitor: every rsp_valid must match the oldest expectation at its due cycle.
    always @(negedge clk) begin
        lsu_exp_t le;
        dma_exp_t de;
        if (rst_l) begin
            if (lsu_rsp_valid) begin
                checks++;
                if (lq.size() == 0) begin
                    failures++;
                    $display("FAIL lsu_unexpected_rsp cyc=%0d got valid=1 expected valid=0", cyc);
                end else begin
                    le = lq.pop_front();
                    if (le.due !== cyc || lsu_rdata_lo !== le.lo || lsu_rdata_hi !== le.hi) begin
                        failures++;
                        $display("FAIL lsu_rsp cyc=%0d got lo=%h hi=%h expected lo=%h hi=%h at cyc=%0d",
                                 cyc, lsu_rdata_lo, lsu_rdata_hi, le.lo, le.hi, le.due);
                    end
                end
            end else if (lq.size() > 0 && lq[0].due <= cyc) begin
                checks++;
                failures++;
                $display("FAIL lsu_missing_rsp cyc=%0d got valid=0 expected valid=1", cyc);
                void'(lq.pop_front());
            end
            if (dma_rsp_valid) begin
                checks++;
                if (dq.size() == 0) begin
                    failures++;
                    $display("FAIL dma_unexpected_rsp cyc=%0d got valid=1 expected valid=0", cyc);
                end else begin
                    de = dq.pop_front();
                    if (de.due !== cyc || dma_rdata !== de.d) begin
                        failures++;
                        $display("FAIL dma_rsp cyc=%0d got %h expected %h at cyc=%0d",
                                 cyc, dma_rdata, de.d, de.due);
                    end
                end
            end else if (dq.size() > 0 && dq[0].due <= cyc) begin
                checks++;
                failures++;
                $display("FAIL dma_missing_rsp cyc=%0d got valid=0 expected valid=1", cyc);
                void'(dq.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lsu(input logic v, input logic w, input logic [AW-1:0] lo, input logic [AW-1:0] hi,
                           input logic [DW-1:0] dlo, input logic [DW-1:0] dhi);
        lsu_valid = v; lsu_write = w; lsu_addr_lo = lo; lsu_addr_hi = hi;
        lsu_wdata_lo = dlo; lsu_wdata_hi = dhi;
    endtask

    task automatic set_dma(input logic v, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        dma_valid = v; dma_write = w; dma_addr = a; dma_wdata = d;
    endtask

    // Bookkeeping for requests the bench expects to fire at the coming edge.
    task automatic accept(input logic lsu_f, input logic dma_f);
        lsu_exp_t le;
        dma_exp_t de;
        if (lsu_f) begin
            if (lsu_write) begin
                mem_model[key(lsu_addr_lo)] = lsu_wdata_lo;
                if (bank(lsu_addr_lo) != bank(lsu_addr_hi)) mem_model[key(lsu_addr_hi)] = lsu_wdata_hi;
            end else begin
                le.due = cyc + LAT;
                le.lo  = mem_model[key(lsu_addr_lo)];
                le.hi  = (bank(lsu_addr_lo) != bank(lsu_addr_hi)) ? mem_model[key(lsu_addr_hi)] : le.lo;
                lq.push_back(le);
            end
        end
        if (dma_f) begin
            if (dma_write) begin
                mem_model[key(dma_addr)] = dma_wdata;
            end else begin
                de.due = cyc + LAT;
                de.d   = mem_model[key(dma_addr)];
                dq.push_back(de);
            end
        end
    endtask

    task automatic idle(input int n);
        set_lsu(0, 0, '0, '0, '0, '0);
        set_dma(0, 0, '0, '0);
        repeat (n) step();
    endtask

    task automatic test_reset();
        rst_l = 1'b0;
        repeat (3) step();
        checks++;
        if (lsu_rsp_valid !== 1'b0 || dma_rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_rsp_valid got lsu=%b dma=%b expected 0/0", lsu_rsp_valid, dma_rsp_valid);
        end
        checks++;
        if (lsu_ready !== 1'b1 || dma_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got lsu=%b dma=%b expected 1/1", lsu_ready, dma_ready);
        end
        rst_l = 1'b1;
        step();
        checks++;
        if (lsu_ready !== 1'b1 || lsu_rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL post_reset got ready=%b valid=%b expected 1/0", lsu_ready, lsu_rsp_valid);
        end
    endtask

    task automatic test_aligned();
        set_lsu(1, 1, 16'h0010, 16'h0010, 39'h27, 39'h0);
        #1 accept(1, 0); step();
        set_lsu(1, 0, 16'h0010, 16'h0010, '0, '0);
        #1 checks++;
        if (lsu_ready !== 1'b1) begin
            failures++;
            $display("FAIL aligned_ready got %b expected 1", lsu_ready);
        end
        accept(1, 0); step();
        idle(LAT + 2);
    endtask

    task automatic test_misaligned();
        set_lsu(1, 1, 16'h000C, 16'h0010, 39'h11, 39'h22);
        #1 accept(1, 0); step();
        set_lsu(1, 0, 16'h000C, 16'h0010, '0, '0);
        #1 accept(1, 0); step();
        idle(LAT + 2);
    endtask

    task automatic test_parallel();
        set_lsu(1, 1, 16'h0004, 16'h0004, 39'h0AA, 39'h0);
        #1 accept(1, 0); step();
        set_lsu(1, 0, 16'h0004, 16'h0004, '0, '0);
        set_dma(1, 1, 16'h0008, 39'h55);
        #1 checks++;
        if (lsu_ready !== 1'b1 || dma_ready !== 1'b1) begin
            failures++;
            $display("FAIL parallel_ready got lsu=%b dma=%b expected 1/1", lsu_ready, dma_ready);
        end
        accept(1, 1); step();
        set_dma(1, 1, 16'h0014, 39'h66);
        for (int i = 0; i < 2; i++) begin
            #1 checks++;
            if (dma_ready !== 1'b0 || lsu_ready !== 1'b1) begin
                failures++;
                $display("FAIL conflict_ready[%0d] got lsu=%b dma=%b expected 1/0", i, lsu_ready, dma_ready);
            end
            accept(1, 0); step();
        end
        set_lsu(1, 0, 16'h0010, 16'h0010, '0, '0);
        #1 checks++;
        if (dma_ready !== 1'b1) begin
            failures++;
            $display("FAIL conflict_release got dma_ready=%b expected 1", dma_ready);
        end
        accept(1, 1); step();
        set_lsu(0, 0, '0, '0, '0, '0);
        set_dma(1, 0, 16'h0014, '0);
        #1 accept(0, 1); step();
        set_dma(1, 0, 16'h0008, '0);
        #1 accept(0, 1); step();
        idle(LAT + 2);
    endtask

    task automatic test_starvation();
        set_lsu(1, 1, 16'h0000, 16'h0000, 39'h3C, 39'h0);
        #1 accept(1, 0); step();
        set_lsu(1, 0, 16'h0000, 16'h0000, '0, '0);
        set_dma(1, 1, 16'h0020, 39'h77);
        for (int i = 0; i < 4; i++) begin
            #1 checks++;
            if (dma_ready !== 1'b0 || lsu_ready !== 1'b1) begin
                failures++;
                $display("FAIL starve_wait[%0d] got lsu=%b dma=%b expected 1/0", i, lsu_ready, dma_ready);
            end
            accept(1, 0); step();
        end
        #1 checks++;
        if (lsu_ready !== 1'b0 || dma_ready !== 1'b1) begin
            failures++;
            $display("FAIL starve_force got lsu=%b dma=%b expected 0/1", lsu_ready, dma_ready);
        end
        accept(0, 1); step();
        set_dma(1, 1, 16'h0020, 39'h78);
        #1 checks++;
        if (lsu_ready !== 1'b1 || dma_ready !== 1'b0) begin
            failures++;
            $display("FAIL starve_cleared got lsu=%b dma=%b expected 1/0", lsu_ready, dma_ready);
        end
        set_dma(0, 0, '0, '0);
        accept(1, 0); step();
        set_lsu(0, 0, '0, '0, '0, '0);
        set_dma(1, 0, 16'h0020, '0);
        #1 accept(0, 1); step();
        idle(LAT + 2);
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] los [5] = '{16'h0000, 16'h0004, 16'h0010, 16'h000C, 16'h000C};
        logic [AW-1:0] his [5] = '{16'h0000, 16'h0004, 16'h0010, 16'h000C, 16'h0010};
        for (int i = 0; i < 5; i++) begin
            set_lsu(1, 0, los[i], his[i], '0, '0);
            set_dma(1, 0, 16'h0008, '0);
            #1 checks++;
            if (lsu_ready !== 1'b1 || dma_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready[%0d] got lsu=%b dma=%b expected 1/1", i, lsu_ready, dma_ready);
            end
            accept(1, 1); step();
        end
        idle(LAT + 2);
    endtask

    task automatic test_reset_mid_read();
        set_lsu(1, 0, 16'h0010, 16'h0010, '0, '0);
        #1 step();
        set_lsu(0, 0, '0, '0, '0, '0);
        rst_l = 1'b0;
        #1 checks++;
        if (lsu_rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_drop got lsu_rsp_valid=%b expected 0", lsu_rsp_valid);
        end
        step();
        rst_l = 1'b1;
        #1 checks++;
        if (lsu_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready got %b expected 1", lsu_ready);
        end
        idle(LAT + 2);
        set_lsu(1, 0, 16'h0010, 16'h0010, '0, '0);
        #1 accept(1, 0); step();
        idle(LAT + 2);
    endtask

    task automatic test_drain();
        checks++;
        if (lq.size() != 0 || dq.size() != 0) begin
            failures++;
            $display("FAIL drain got pending lsu=%0d dma=%0d expected 0/0", lq.size(), dq.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_aligned();
        test_misaligned();
        test_parallel();
        test_starvation();
        test_back_to_back();
        test_reset_mid_read();
        test_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
